// File: rtl/alu_seq_md.sv
// alu_seq_md: registered EX-stage ALU.
// Single-cycle ops (arith, logic, compare, shift) finish in one clock.
// Iterative multiply/divide runs in a small FSM and writes internal HI/LO.
//
// Handshake: start is sampled only at an edge where busy=0 (FSM in IDLE).
// A single-cycle op raises done for the next cycle with busy staying 0.
// A multi-cycle op raises busy from the accepting edge through the FIX cycle.
// done then pulses for one cycle as busy falls.
// A start presented while busy=1 is dropped; it is neither latched nor queued.
// A start presented during the done cycle is accepted, so ops can run back to back.
module alu_seq_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [SHW-1:0]   const_amt,
  input  logic             amt_sel,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             ovf_flag,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Operation encoding
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MULT  = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;

  // The step counter runs 0..WIDTH-1, giving one radix-2 step per CALC edge.
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Iterative engine registers. For multiply, {acc_hi, acc_lo} is the partial
  // product with the multiplier shifting out of acc_lo. For divide, acc_hi is
  // the partial remainder and acc_lo shifts the dividend out / quotient in.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;
  logic [SHW-1:0]   cnt;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic             is_div_r;

  // Operation decode
  logic is_multi;
  logic is_div;
  logic is_signed;
  logic dz_start;

  assign is_multi  = (op >= OP_MULT) && (op <= OP_DIVU);
  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign dz_start  = is_div && (y == '0);

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  // SUB, SLT and SLTU share one adder fed with ~y and a carry-in of 1.
  logic             alu_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_full;
  logic             c_out;
  logic             c_msb;
  logic             ovf_raw;
  logic             slt_bit;
  logic             sltu_bit;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign alu_sub  = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  assign b_eff    = alu_sub ? ~y : y;
  assign sum_full = {1'b0, x} + {1'b0, b_eff} + {{WIDTH{1'b0}}, alu_sub};
  assign c_out    = sum_full[WIDTH];
  // Carry into the MSB recovered from the MSB sum bit and its two inputs.
  assign c_msb    = x[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_full[WIDTH-1];
  assign ovf_raw  = c_msb ^ c_out;
  // Sign of the true difference, valid even when x-y overflows.
  assign slt_bit  = sum_full[WIDTH-1] ^ ovf_raw;
  // x-y with no carry-out means a borrow, i.e. x<y unsigned.
  assign sltu_bit = ~c_out;
  assign shamt    = amt_sel ? x[SHW-1:0] : const_amt;

  // Select the single-cycle result; overflow only reported for ADD/SUB
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res = sum_full[WIDTH-1:0];
        alu_ovf = ovf_raw;
      end
      OP_AND:  alu_res = x & y;
      OP_OR:   alu_res = x | y;
      OP_XOR:  alu_res = x ^ y;
      OP_NOR:  alu_res = ~(x | y);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, sltu_bit};
      OP_SLL:  alu_res = y << shamt;
      OP_SRL:  alu_res = y >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(y) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative multiply / divide step logic
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Signed ops run on magnitudes; the sign is restored in FIX.
  assign x_mag = (is_signed && x[WIDTH-1]) ? -x : x;
  assign y_mag = (is_signed && y[WIDTH-1]) ? -y : y;

  // Shift-add multiply: conditionally add the multiplicand, then shift right.
  assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opb : {WIDTH{1'b0}})};

  // Restoring divide: bring in the next dividend bit and trial-subtract.
  // The partial remainder is always below the divisor, so bit WIDTH of diff
  // is set exactly when the trial subtraction borrows.
  assign rem_sh = {acc_hi, acc_lo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, opb};

  // Sign correction. MIN_INT / -1 needs no special case: the magnitude
  // quotient 2^(WIDTH-1) negates back onto itself with a zero remainder.
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign q_fix    = neg_q ? -acc_lo : acc_lo;
  assign r_fix    = neg_r ? -acc_hi : acc_hi;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: divide by zero skips CALC and goes straight to FIX
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start && is_multi) state_nxt = dz_start ? S_FIX : S_CALC;
      end
      S_CALC: begin
        if (cnt == CNT_LAST) state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, output registers and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      result      <= '0;
      zero_flag   <= 1'b0;
      ovf_flag    <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opb         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      is_div_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_multi) begin
              cnt      <= '0;
              neg_q    <= is_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
              neg_r    <= (op == OP_DIV) && x[WIDTH-1];
              dz       <= dz_start;
              is_div_r <= is_div;
              acc_hi   <= '0;
              // On divide by zero the raw dividend is kept to become hi.
              acc_lo   <= dz_start ? x : x_mag;
              opb      <= y_mag;
            end else begin
              result    <= alu_res;
              zero_flag <= (alu_res == '0);
              ovf_flag  <= alu_ovf;
              done      <= 1'b1;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_ONE;
          if (is_div_r) begin
            if (!diff[WIDTH]) begin
              acc_hi <= diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= rem_sh[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          done        <= 1'b1;
          div_by_zero <= dz;
          if (dz) begin
            hi <= acc_lo;
            lo <= '1;
          end else if (is_div_r) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
